bcd_time_counter: RTL and testbench
===================================

# bcd_time_counter

Parametrised BCD timekeeping core for the alarm-clock design. It generalises the fixed MM:SS free-running counter to 1–3 cascaded BCD fields (SS, MM:SS or HH:MM:SS) with a configurable top-field modulus and a built-in seconds prescaler. It adds run/stop, validated parallel load, per-field inc/dec editing (push-button service use) and tick/wrap strobes. It sits between the board clock and the service blocks (time set, alarm set, alarm check) and feeds the 7-segment conversion path.

## Interface
- TICK_DIV, 100_000_000: clk cycles per one-second tick; must be ≥2.
- NFIELDS, 2: number of 2-digit BCD fields, 1..3; field 0 = seconds.
- TOP_MOD, 60: modulus of the top field (field NFIELDS-1), 2..99, e.g. 24 for hours; lower fields are always mod 60.
- W = 8*NFIELDS (localparam): time bus width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-high reset.
- run  in  1  1 = prescaler counts; 0 = time frozen.
- load_valid  in  1  one-cycle load request.
- load_time  in  W  BCD time to load; field i = bits [8i+7:8i].
- edit_inc  in  1  pulse: increment selected field.
- edit_dec  in  1  pulse: decrement selected field.
- field_sel  in  2  field index for edit.
- alarm_time  in  W  compare value (ALARM_MATCH_EN only).
- time_o  out  W  current time, BCD.
- tick_o  out  1  one-cycle pulse when time advances by a tick.
- wrap_o  out  1  one-cycle pulse when whole counter rolls to all-zero from a tick.
- load_err  out  1  one-cycle pulse: load rejected.
- match_o  out  1  one-cycle pulse on alarm match (ALARM_MATCH_EN only).

## Operation
- Prescaler `pre` counts 0..TICK_DIV-1 while run=1 and holds while run=0. A tick event occurs on the cycle with pre==TICK_DIV-1 and run=1; `pre` then returns to 0.
- A tick increments field 0 BCD-wise: the low digit wraps 9→0 with a carry to the high digit. A field at modulus-1 wraps to 00 and carries to the next field. The top field wraps at TOP_MOD-1 without carry out. When all fields wrap on the same tick, wrap_o fires.
- Load: accepted when every digit is 0..9 and each field is below its modulus. On acceptance, time_o takes load_time and `pre` is cleared to 0. Otherwise time is unchanged and load_err pulses. There is no ready signal: a load is always consumed in its cycle.
- Edit: inc/dec the selected field modulo its modulus (59↔00, or TOP_MOD-1↔00), with no carry or borrow into other fields. Edit is ignored if field_sel ≥ NFIELDS or if edit_inc and edit_dec are both 1. `pre` is unaffected.
- Priority per cycle: resetn > load > edit > tick.
  - A tick coinciding with an accepted load is discarded, since the load restarts `pre`.
  - A tick coinciding with an edit, or with a rejected load, sets a `pend` flag and is applied on the next cycle. `pend` is applied even if run=0. A pending tick that meets another edit stays pending.
- Reset: time_o=0, pre=0, pend=0, tick_o=wrap_o=load_err=match_o=0.

## Timing
- All outputs are registered.
- time_o updates on the clock edge ending the tick, load or edit cycle.
- tick_o and wrap_o are high in the first cycle the new time_o is visible.
- load_err is high the cycle after the rejected load_valid.
- With run held at 1 and no loads, tick_o has a period of exactly TICK_DIV cycles. The first tick comes TICK_DIV cycles after reset deasserts.
- Deasserting run mid-count holds `pre`. Reasserting it resumes from the held value.
- Reset mid-operation takes effect on the next edge regardless of pending load, edit or tick.

## Configuration
- ALARM_MATCH_EN defined: compares time_o with alarm_time each cycle. match_o pulses one cycle when equality first arises, i.e. on the rising edge of equality, registered. No re-pulse occurs while equality holds. A load to a time equal to alarm_time does pulse.
- ALARM_MATCH_EN undefined: alarm_time is unused, and match_o is tied to 0 with no compare logic.

## Test plan
(TICK_DIV=4, NFIELDS=2, TOP_MOD=60 unless noted.)
- Reset, then run=1 for 8 cycles: time_o=0x0001 after cycle 4 and 0x0002 after cycle 8; tick_o pulses twice; run=0 freezes the value.
- Load 0x5959, run: after 4 cycles time_o=0x0000, with tick_o and wrap_o high together. With NFIELDS=3 and TOP_MOD=24, loading 0x235959 then ticking gives 0x000000 with wrap_o.
- Load 0x5A00, then 0x6000: load_err pulses each time; time_o is unchanged; `pre` is not cleared.
- Edit with field_sel=0: inc at 0x1259 gives 0x1200; dec at 0x1200 gives 0x1259. With field_sel=2 and NFIELDS=2 there is no change.
- edit_inc on field 0 at 0x0058, in the same cycle as a tick: the next cycle shows 0x0059; the following cycle shows 0x0100 with tick_o.
- ALARM_MATCH_EN, alarm_time=0x0003, run from reset: match_o pulses once, in the same cycle time_o becomes 0x0003. A subsequent load of 0x0003 pulses match_o again.

Source files
------------

// File: rtl/bcd_time_counter.sv
// BCD SS / MM:SS / HH:MM:SS counter with prescaler, load, field edit, strobes.
// Define ALARM_MATCH_EN to build the registered alarm-equality pulse on match_o.
module bcd_time_counter #(
  parameter int TICK_DIV = 100_000_000,
  parameter int NFIELDS  = 2,
  parameter int TOP_MOD  = 60,
  localparam int W       = 8*NFIELDS
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         run,
  input  logic         load_valid,
  input  logic [W-1:0] load_time,
  input  logic         edit_inc,
  input  logic         edit_dec,
  input  logic [1:0]   field_sel,
  input  logic [W-1:0] alarm_time,
  output logic [W-1:0] time_o,
  output logic         tick_o,
  output logic         wrap_o,
  output logic         load_err,
  output logic         match_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  function automatic int fmod(int i);
    return (i == NFIELDS - 1) ? TOP_MOD : 60;
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic [7:0] bcd_inc(logic [7:0] f, int m);
    if (f == to_bcd(m - 1)) return 8'h00;
    if (f[3:0] == 4'd9) return {f[7:4] + 4'd1, 4'h0};
    return {f[7:4], f[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(logic [7:0] f, int m);
    if (f == 8'h00) return to_bcd(m - 1);
    if (f[3:0] == 4'd0) return {f[7:4] - 4'd1, 4'h9};
    return {f[7:4], f[3:0] - 4'd1};
  endfunction

  function automatic logic fld_ok(logic [7:0] f, int m);
    int v;
    if (f[7:4] > 4'd9 || f[3:0] > 4'd9) return 1'b0;
    v = int'(f[7:4]) * 10 + int'(f[3:0]);
    return v < m;
  endfunction

  logic [W-1:0]  r_time;
  logic [PW-1:0] r_pre;
  logic          r_pend;
  logic          r_tick;
  logic          r_wrap;
  logic          r_err;

  logic [W-1:0]  w_tick_time;
  logic [W-1:0]  w_edit_time;
  logic [W-1:0]  w_time_nxt;
  logic [PW-1:0] w_pre_nxt;
  logic          w_pend_nxt;
  logic          w_tick_nxt;
  logic          w_wrap_nxt;
  logic          w_err_nxt;
  logic          w_carry;
  logic          w_tick_ev;
  logic          w_tick_req;
  logic          w_edit_ok;
  logic          w_load_ok;
  logic          w_load_acc;

  assign w_tick_ev  = run && (r_pre == PRE_MAX);
  assign w_tick_req = w_tick_ev || r_pend;
  assign w_edit_ok  = (edit_inc ^ edit_dec) && (int'(field_sel) < NFIELDS);
  assign w_load_acc = load_valid && w_load_ok;

  // Ripple the seconds increment up; carry survives only through wrapping fields
  always_comb begin
    w_tick_time = r_time;
    w_carry     = 1'b1;
    for (int i = 0; i < NFIELDS; i++) begin
      if (w_carry) begin
        w_tick_time[8*i +: 8] = bcd_inc(r_time[8*i +: 8], fmod(i));
        w_carry = (r_time[8*i +: 8] == to_bcd(fmod(i) - 1));
      end
    end
  end

  always_comb begin
    w_edit_time = r_time;
    w_load_ok   = 1'b1;
    for (int i = 0; i < NFIELDS; i++) begin
      if (int'(field_sel) == i) begin
        w_edit_time[8*i +: 8] = edit_inc ?
          bcd_inc(r_time[8*i +: 8], fmod(i)) :
          bcd_dec(r_time[8*i +: 8], fmod(i));
      end
      if (!fld_ok(load_time[8*i +: 8], fmod(i))) w_load_ok = 1'b0;
    end
  end

  always_comb begin
    w_time_nxt = r_time;
    w_pend_nxt = r_pend;
    w_tick_nxt = 1'b0;
    w_wrap_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    if (!run)                w_pre_nxt = r_pre;
    else if (r_pre == PRE_MAX) w_pre_nxt = '0;
    else                     w_pre_nxt = r_pre + 1'b1;
    // A tick that cannot be applied this cycle is deferred via pend
    if (w_load_acc) begin
      w_time_nxt = load_time;
      w_pre_nxt  = '0;
      w_pend_nxt = 1'b0;
    end else if (load_valid) begin
      w_err_nxt  = 1'b1;
      w_pend_nxt = w_tick_req;
    end else if (w_edit_ok) begin
      w_time_nxt = w_edit_time;
      w_pend_nxt = w_tick_req;
    end else if (w_tick_req) begin
      w_time_nxt = w_tick_time;
      w_tick_nxt = 1'b1;
      w_wrap_nxt = w_carry;
      w_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_time <= '0;
      r_pre  <= '0;
      r_pend <= 1'b0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_time <= w_time_nxt;
      r_pre  <= w_pre_nxt;
      r_pend <= w_pend_nxt;
      r_tick <= w_tick_nxt;
      r_wrap <= w_wrap_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign time_o   = r_time;
  assign tick_o   = r_tick;
  assign wrap_o   = r_wrap;
  assign load_err = r_err;

`ifdef ALARM_MATCH_EN
  logic r_match;
  logic w_eq_now;
  logic w_eq_nxt;

  assign w_eq_now = (r_time == alarm_time);
  assign w_eq_nxt = (w_time_nxt == alarm_time);

  // Rising edge of equality, plus any accepted load landing on the alarm
  always_ff @(posedge clk) begin
    if (resetn) r_match <= 1'b0;
    else        r_match <= w_eq_nxt && (!w_eq_now || w_load_acc);
  end

  assign match_o = r_match;
`else
  logic w_unused_alarm;
  assign w_unused_alarm = ^alarm_time;
  assign match_o = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter: MM:SS (TICK_DIV=4) and HH:MM:SS (TOP_MOD=24).
// Alarm checks follow ALARM_MATCH_EN; without it match_o must stay 0.
module tb_bcd_time_counter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        run;
  logic        lv;
  logic [15:0] lt;
  logic        ei;
  logic        ed;
  logic [1:0]  fs;
  logic [15:0] alarm;
  logic [15:0] time_o;
  logic        tick_o;
  logic        wrap_o;
  logic        err_o;
  logic        match_o;

  logic        d3_run;
  logic        d3_lv;
  logic [23:0] d3_lt;
  logic [23:0] d3_alarm;
  logic [23:0] time3;
  logic        tick3;
  logic        wrap3;
  logic        err3;
  logic        match3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bcd_time_counter #(.TICK_DIV(4), .NFIELDS(2), .TOP_MOD(60)) u_dut (
    .clk(clk), .resetn(resetn), .run(run),
    .load_valid(lv), .load_time(lt),
    .edit_inc(ei), .edit_dec(ed), .field_sel(fs),
    .alarm_time(alarm), .time_o(time_o), .tick_o(tick_o),
    .wrap_o(wrap_o), .load_err(err_o), .match_o(match_o)
  );

  bcd_time_counter #(.TICK_DIV(4), .NFIELDS(3), .TOP_MOD(24)) u_dut3 (
    .clk(clk), .resetn(resetn), .run(d3_run),
    .load_valid(d3_lv), .load_time(d3_lt),
    .edit_inc(1'b0), .edit_dec(1'b0), .field_sel(2'd0),
    .alarm_time(d3_alarm), .time_o(time3), .tick_o(tick3),
    .wrap_o(wrap3), .load_err(err3), .match_o(match3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    resetn = 1'b1; run = 1'b0; lv = 1'b0; lt = '0;
    ei = 1'b0; ed = 1'b0; fs = '0; alarm = 16'hFFFF;
    d3_run = 1'b0; d3_lv = 1'b0; d3_lt = '0; d3_alarm = 24'hFFFFFF;
    step(2);
    resetn = 1'b0;
    chk("rst_time", 32'(time_o), 32'h0);
    chk("rst_tick", 32'(tick_o), 32'h0);
    chk("rst_wrap", 32'(wrap_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_match", 32'(match_o), 32'h0);
    chk("rst_time3", 32'(time3), 32'h0);

    run = 1'b1;
    step(3);
    chk("pre_time", 32'(time_o), 32'h0000);
    chk("pre_tick", 32'(tick_o), 32'h0);
    step(1);
    chk("t1_time", 32'(time_o), 32'h0001);
    chk("t1_tick", 32'(tick_o), 32'h1);
    step(3);
    chk("gap_tick", 32'(tick_o), 32'h0);
    step(1);
    chk("t2_time", 32'(time_o), 32'h0002);
    chk("t2_tick", 32'(tick_o), 32'h1);
    step(1);
    run = 1'b0;
    step(5);
    chk("frozen", 32'(time_o), 32'h0002);

    lt = 16'h5959; lv = 1'b1;
    step(1);
    lv = 1'b0;
    chk("ld5959", 32'(time_o), 32'h5959);
    chk("ld_err0", 32'(err_o), 32'h0);
    run = 1'b1;
    step(3);
    chk("pre_wrap", 32'(time_o), 32'h5959);
    step(1);
    chk("wrap_time", 32'(time_o), 32'h0000);
    chk("wrap_tick", 32'(tick_o), 32'h1);
    chk("wrap_o", 32'(wrap_o), 32'h1);

    step(1);
    lt = 16'h5A00; lv = 1'b1;
    step(1);
    chk("bad5A_err", 32'(err_o), 32'h1);
    chk("bad5A_time", 32'(time_o), 32'h0000);
    lt = 16'h6000;
    step(1);
    chk("bad60_err", 32'(err_o), 32'h1);
    chk("bad60_time", 32'(time_o), 32'h0000);
    lv = 1'b0;
    step(1);
    chk("nopreclr_time", 32'(time_o), 32'h0001);
    chk("nopreclr_tick", 32'(tick_o), 32'h1);
    chk("err_clear", 32'(err_o), 32'h0);
    run = 1'b0;

    d3_lt = 24'h235959; d3_lv = 1'b1;
    step(1);
    d3_lv = 1'b0;
    chk("d3_ld", 32'(time3), 32'h235959);
    d3_run = 1'b1;
    step(4);
    d3_run = 1'b0;
    chk("d3_wrap_time", 32'(time3), 32'h000000);
    chk("d3_wrap", 32'(wrap3), 32'h1);
    chk("d3_tick", 32'(tick3), 32'h1);
    d3_lt = 24'h240000; d3_lv = 1'b1;
    step(1);
    d3_lv = 1'b0;
    chk("d3_bad_err", 32'(err3), 32'h1);
    chk("d3_bad_time", 32'(time3), 32'h000000);

    lt = 16'h1259; lv = 1'b1;
    step(1);
    lv = 1'b0;
    fs = 2'd0; ei = 1'b1;
    step(1);
    chk("inc_f0", 32'(time_o), 32'h1200);
    ei = 1'b0; ed = 1'b1;
    step(1);
    chk("dec_f0", 32'(time_o), 32'h1259);
    fs = 2'd1;
    step(1);
    chk("dec_f1", 32'(time_o), 32'h1159);
    ed = 1'b0;
    lt = 16'h5900; lv = 1'b1;
    step(1);
    lv = 1'b0;
    fs = 2'd1; ei = 1'b1;
    step(1);
    chk("inc_f1_wrap", 32'(time_o), 32'h0000);
    chk("edit_nowrap", 32'(wrap_o), 32'h0);
    fs = 2'd2;
    step(1);
    chk("sel2_ign", 32'(time_o), 32'h0000);
    fs = 2'd0; ed = 1'b1;
    step(1);
    chk("both_ign", 32'(time_o), 32'h0000);
    ei = 1'b0; ed = 1'b0;

    lt = 16'h0058; lv = 1'b1;
    step(1);
    lv = 1'b0; run = 1'b1;
    step(3);
    chk("pend_pre", 32'(time_o), 32'h0058);
    fs = 2'd0; ei = 1'b1;
    step(1);
    chk("pend_edit", 32'(time_o), 32'h0059);
    chk("pend_notick", 32'(tick_o), 32'h0);
    ei = 1'b0; run = 1'b0;
    step(1);
    chk("pend_apply", 32'(time_o), 32'h0100);
    chk("pend_tick", 32'(tick_o), 32'h1);
    step(1);
    chk("pend_done", 32'(time_o), 32'h0100);
    chk("pend_tick0", 32'(tick_o), 32'h0);

    run = 1'b1; lt = 16'h2222; lv = 1'b1; resetn = 1'b1;
    step(1);
    lv = 1'b0; resetn = 1'b0;
    chk("midrst_time", 32'(time_o), 32'h0000);
    chk("midrst_err", 32'(err_o), 32'h0);
    step(3);
    chk("midrst_pre", 32'(time_o), 32'h0000);
    step(1);
    chk("midrst_t1", 32'(time_o), 32'h0001);
    run = 1'b0;

    resetn = 1'b1;
    step(1);
    resetn = 1'b0; alarm = 16'h0003; run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
`ifdef ALARM_MATCH_EN
      chk($sformatf("alm_k%0d", k), 32'(match_o), 32'(k == 12));
`else
      chk($sformatf("nomatch_k%0d", k), 32'(match_o), 32'h0);
`endif
    end
    chk("alm_time", 32'(time_o), 32'h0003);
    run = 1'b0;
    step(1);
    chk("alm_hold", 32'(match_o), 32'h0);
    lt = 16'h0003; lv = 1'b1;
    step(1);
    lv = 1'b0;
`ifdef ALARM_MATCH_EN
    chk("alm_load", 32'(match_o), 32'h1);
`else
    chk("alm_load", 32'(match_o), 32'h0);
`endif
    step(1);
    chk("alm_after", 32'(match_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
